// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: sequences redirects, load-use bubbles and the halt/drain/resume flow
// around the branch and hazard units.
module pc_sequencer #(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    input  logic             ld_use_stall,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  halt_pc_q;
    logic [DW-1:0]    drain_cnt_q;
    logic             halted_q;
    logic             misalign_q;
    logic [CNT_W-1:0] redirect_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic redir;
    logic hreq;
    logic unused_brpc;

    assign redir = ex_valid & PcSel & ~Halt;
    assign hreq  = ex_valid & Halt;

    // Upper target bits lie outside the PC space and are intentionally dropped.
    assign unused_brpc = ^BrPC[31:PC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            pc_q           <= '0;
            halt_pc_q      <= '0;
            drain_cnt_q    <= '0;
            halted_q       <= 1'b0;
            misalign_q     <= 1'b0;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hreq) begin
                        halt_pc_q   <= BrPC[PC_W-1:0];
                        drain_cnt_q <= DW'(DRAIN_CYC - 1);
                        state_q     <= StDrain;
                    end else if (redir) begin
                        pc_q <= {BrPC[PC_W-1:2], 2'b00};
                        if (redirect_cnt_q != {CNT_W{1'b1}}) begin
                            redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
                        end
                        if (BrPC[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (ld_use_stall) begin
                        if (stall_cnt_q != {CNT_W{1'b1}}) begin
                            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_q <= pc_q + PC_W'(4);
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == '0) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                        pc_q     <= halt_pc_q;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DW'(1);
                    end
                end
                StHalted: begin
                    if (resume) begin
                        pc_q     <= halt_pc_q + PC_W'(4);
                        halted_q <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Inputs are masked by rst_n so the reset-time outputs match plain RUN fetch.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        unique case (state_q)
            StRun: begin
                if (rst_n) begin
                    if (hreq) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (redir) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ld_use_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            StDrain, StHalted: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    assign pc           = pc_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;

    localparam int unsigned PC_W      = 9;
    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int          PC_MOD    = 1 << PC_W;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid = 1'b0;
    logic             PcSel = 1'b0;
    logic [31:0]      BrPC = '0;
    logic             Halt = 1'b0;
    logic             ld_use_stall = 1'b0;
    logic             resume = 1'b0;
    logic [PC_W-1:0]  pc;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    pc_sequencer #(
        .PC_W      (PC_W),
        .DRAIN_CYC (DRAIN_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .Halt         (Halt),
        .ld_use_stall (ld_use_stall),
        .resume       (resume),
        .pc           (pc),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .halted       (halted),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: drain_left counts remaining drain cycles; 0 means not draining.
    int m_pc, m_halt_pc, m_drain_left, m_rc, m_sc;
    bit m_halted, m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_halt_pc = 0; m_drain_left = 0; m_rc = 0; m_sc = 0;
        m_halted = 0; m_mis = 0;
    endtask

    task automatic model_step();
        bit redir, hreq;
        redir = ex_valid && PcSel && !Halt;
        hreq  = ex_valid && Halt;
        if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_halted = 1;
                m_pc     = m_halt_pc;
            end
        end else if (m_halted) begin
            if (resume) begin
                m_pc     = (m_halt_pc + 4) % PC_MOD;
                m_halted = 0;
            end
        end else if (hreq) begin
            m_halt_pc    = int'(BrPC % 32'(PC_MOD));
            m_drain_left = DRAIN_CYC;
        end else if (redir) begin
            m_pc = int'(BrPC % 32'(PC_MOD)) / 4 * 4;
            if (m_rc < CNT_MAX) m_rc++;
            if (BrPC % 4 != 0) m_mis = 1;
        end else if (ld_use_stall) begin
            if (m_sc < CNT_MAX) m_sc++;
        end else begin
            m_pc = (m_pc + 4) % PC_MOD;
        end
    endtask

    task automatic check_comb();
        bit redir, hreq, busy;
        redir = ex_valid && PcSel && !Halt;
        hreq  = ex_valid && Halt;
        busy  = m_halted || (m_drain_left > 0);
        if (busy || hreq) begin
            check("pc_en_stop", 32'(pc_en), 32'd0);
            check("if_id_flush_stop", 32'(if_id_flush), 32'd1);
            check("id_ex_flush_stop", 32'(id_ex_flush), 32'd1);
            if (busy) check("if_id_en_stop", 32'(if_id_en), 32'd0);
        end else if (redir) begin
            check("pc_en_redir", 32'(pc_en), 32'd1);
            check("if_id_en_redir", 32'(if_id_en), 32'd1);
            check("if_id_flush_redir", 32'(if_id_flush), 32'd1);
            check("id_ex_flush_redir", 32'(id_ex_flush), 32'd1);
        end else if (ld_use_stall) begin
            check("pc_en_stall", 32'(pc_en), 32'd0);
            check("if_id_en_stall", 32'(if_id_en), 32'd0);
            check("if_id_flush_stall", 32'(if_id_flush), 32'd0);
            check("id_ex_flush_stall", 32'(id_ex_flush), 32'd1);
        end else begin
            check("pc_en_run", 32'(pc_en), 32'd1);
            check("if_id_en_run", 32'(if_id_en), 32'd1);
            check("if_id_flush_run", 32'(if_id_flush), 32'd0);
            check("id_ex_flush_run", 32'(id_ex_flush), 32'd0);
        end
    endtask

    task automatic check_regs();
        check("pc", 32'(pc), 32'(m_pc));
        check("halted", 32'(halted), 32'(m_halted));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
        check("redirect_cnt", 32'(redirect_cnt), 32'(m_rc));
        check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    endtask

    // Inputs stay stable across the negedge check and the following posedge.
    task automatic step();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    task automatic drive(input bit ev, input bit ps, input bit h, input logic [31:0] br,
                         input bit st, input bit rs);
        ex_valid = ev; PcSel = ps; Halt = h; BrPC = br; ld_use_stall = st; resume = rs;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_pc_en"}, 32'(pc_en), 32'd1);
        check({tag, "_if_id_en"}, 32'(if_id_en), 32'd1);
        check({tag, "_if_id_flush"}, 32'(if_id_flush), 32'd0);
        check({tag, "_id_ex_flush"}, 32'(id_ex_flush), 32'd0);
    endtask

    initial begin
        model_reset();
        // Held in reset with active-looking inputs: outputs must show plain RUN fetch.
        drive(1, 1, 0, 32'h84, 1, 1);
        #12;
        check_reset_outputs("reset");
        check("reset_cnt", 32'(redirect_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        repeat (4) step();
        check("plan_pc_0x10", 32'(pc), 32'h10);

        drive(1, 1, 0, 32'h84, 0, 0); step();
        check("plan_redir_0x84", 32'(pc), 32'h84);
        drive(1, 1, 0, 32'h86, 0, 0); step();
        check("plan_misalign_pc", 32'(pc), 32'h84);
        check("plan_misalign_err", 32'(misalign_err), 32'd1);

        drive(1, 1, 0, 32'h20, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step(); step();
        check("plan_stall_pc", 32'(pc), 32'h20);
        check("plan_stall_cnt", 32'(stall_cnt), 32'd2);
        drive(1, 1, 0, 32'h40, 1, 0); step();
        check("plan_stall_redir_pc", 32'(pc), 32'h40);
        drive(0, 1, 1, 32'h100, 1, 0); step();

        drive(1, 1, 1, 32'h30, 0, 0); step();
        drive(1, 1, 0, 32'h88, 1, 1); step(); step();
        check("plan_halted", 32'(halted), 32'd1);
        check("plan_halt_pc", 32'(pc), 32'h30);
        drive(0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1); step();
        check("plan_resume_pc", 32'(pc), 32'h34);
        drive(0, 0, 0, 0, 0, 0); step();

        drive(1, 1, 0, 32'h1FC, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        check("plan_wrap_pc", 32'(pc), 32'h0);
        drive(1, 1, 0, 32'hFFFF_0008, 0, 0); step();
        check("plan_upper_bits_pc", 32'(pc), 32'h8);

        drive(1, 1, 1, 32'h44, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_reset_outputs("drain_reset");
        @(posedge clk); #1; rst_n = 1'b1;
        step(); step();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] br;
            br = $urandom;
            if ($urandom_range(0, 1) == 0) br = br & 32'h1FC;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, br, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            if (i == 1500) begin
                drive(0, 0, 0, 0, 0, 0);
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_reset_outputs("random_reset");
                @(posedge clk); #1; rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences the pipeline around the branch unit's redirect decisions. It consumes the EX-stage `PcSel`/`BrPC`/`Halt` outputs and the hazard unit's load-use request. It produces the PC, stage enables, flush strobes and halt status. It sits between the branch unit, the hazard unit and the IF stage, replacing the bare PC register plus 2:1 mux.

## Interface

- `PC_W`, 9: PC width in bits; instruction memory is word-addressed by `pc[PC_W-1:2]`.
- `DRAIN_CYC`, 2: cycles that older instructions (MEM/WB) are allowed to retire before halt completes; must be at least 1.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: single clock, all state updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX stage holds a real (non-bubble) instruction; gates `PcSel` and `Halt`.
- `PcSel` in 1: branch unit requests a redirect.
- `BrPC` in 32: redirect target from the branch unit.
- `Halt` in 1: EX instruction is a halt; it arrives together with `PcSel=1`.
- `ld_use_stall` in 1: hazard unit requests a one-cycle bubble.
- `resume` in 1: single-cycle pulse that restarts execution from the HALTED state.
- `pc` out PC_W: current fetch PC (registered).
- `pc_en` out 1: IF/PC advance enable.
- `if_id_en` out 1: IF/ID register load enable.
- `if_id_flush` out 1: zero the IF/ID register at the next edge.
- `id_ex_flush` out 1: zero the ID/EX register at the next edge.
- `halted` out 1: core stopped (registered).
- `misalign_err` out 1: sticky; set when an accepted redirect target has `BrPC[1:0]!=0`.
- `redirect_cnt` out CNT_W: count of taken redirects, saturating.
- `stall_cnt` out CNT_W: count of load-use bubbles, saturating.

## Operation

- States: RUN, DRAIN, HALTED.
- Definitions:
  - `redir = ex_valid & PcSel & ~Halt`
  - `hreq = ex_valid & Halt`
- RUN, priority `hreq` > `redir` > `ld_use_stall` > normal:
  - **`hreq`:**
    - `pc` is held.
    - `halt_pc` is captured as `BrPC[PC_W-1:0]`, which equals the halt instruction's PC.
    - Both flushes are asserted and `pc_en=0`.
    - Next state is DRAIN with `drain_cnt = DRAIN_CYC-1`.
  - **`redir`:**
    - `pc <= {BrPC[PC_W-1:2],2'b00}`.
    - `if_id_flush=1`, `id_ex_flush=1`, `pc_en=1`, `if_id_en=1`.
    - `redirect_cnt` increments.
    - If `BrPC[1:0]!=0`, set `misalign_err`.
    - `ld_use_stall` is ignored this cycle because the stalled instruction is squashed.
  - **`ld_use_stall`:**
    - `pc` is held, `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`, `if_id_flush=0`.
    - `stall_cnt` increments.
  - **Normal:**
    - `pc <= pc + 4`, modulo 2^PC_W (wraps to 0).
    - `pc_en=1`, `if_id_en=1`, both flushes 0.
- DRAIN:
  - `pc` is held, `pc_en=0`, `if_id_en=0`, both flushes 1.
  - All inputs except `rst_n` are ignored.
  - `drain_cnt` decrements each cycle; at 0, next state is HALTED.
- HALTED:
  - `halted=1`, `pc` held at `halt_pc`, `pc_en=0`, `if_id_en=0`, both flushes 1.
  - On `resume`: `pc <= halt_pc + 4` (wrapping), `halted` goes to 0 and next state is RUN.
  - `resume` in RUN or DRAIN is ignored.
- Flush/enable outputs are combinational (Mealy) from state and inputs. `pc`, `halted`, `misalign_err` and the counters are registered.
- Counters saturate at all-ones. They are cleared only by reset.
- `misalign_err` is cleared only by reset.
- `BrPC` bits above `PC_W-1` are discarded.

## Timing

- Reset (async assert, sync-to-clk deassert handled externally) sets:
  - state RUN, `pc=0`, `halted=0`, `misalign_err=0`, counters 0, `drain_cnt=0`, `halt_pc=0`.
  - While `rst_n=0`: `pc_en=1`, `if_id_en=1`, flushes 0 (combinational from RUN with inputs masked).
- Redirect latency: the target appears on `pc` the cycle after `redir` is sampled. Exactly one fetched instruction (in IF/ID) and one decoded instruction (in ID/EX) are squashed.
- Load-use stall: one bubble per asserted cycle. `pc` is unchanged across the stall edge.
- Halt: `halted` rises exactly `DRAIN_CYC` edges after the `hreq` edge. Execution restarts at `halt_pc+4` on the edge that samples `resume`.
- Reset mid-DRAIN or mid-HALTED: the block returns to RUN at `pc=0` immediately and asynchronously.
- `ex_valid=0`: `PcSel` and `Halt` have no effect, including under `ld_use_stall`.

## Test plan

- Reset then 4 free-running cycles → `pc` goes 0, 4, 8, 12, 16; flushes 0; counters 0.
- At `pc=0x10`, `ex_valid=1, PcSel=1, BrPC=0x84` → both flushes high that cycle, next `pc=0x084`, `redirect_cnt=1`. Repeat with `BrPC=0x86` → `pc=0x084`, `misalign_err=1`.
- `ld_use_stall=1` for 2 cycles at `pc=0x20` → `pc` stays `0x20`, `if_id_en=0`, `id_ex_flush=1` both cycles, `stall_cnt=2`. The same cycle with a simultaneous `redir` to `0x40` → `pc=0x40`, `stall_cnt` unchanged.
- `Halt` with `BrPC=0x30`, `DRAIN_CYC=2` → `halted=1` two edges later, `pc=0x30`. `resume` pulse → `pc=0x34`, `halted=0`. `resume` during DRAIN → ignored.
- `pc=0x1FC` (PC_W=9) with normal advance → `pc=0x000`. `BrPC=0xFFFF_0008` → `pc=0x008`.
- `rst_n` pulled low during DRAIN → `pc=0`, `halted=0`, state RUN without a clock edge; normal fetch resumes after release.
